// File: rtl/bk_adder_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module  : bk_adder_arbiter (with brent_kung_adder_nbit)                     |
// | Brief   : Round-robin arbiter sharing one Brent-Kung adder across NUM_REQ   |
// |           requesters, with a tagged valid/ready response channel.           |
// | Revision: 1.0 - initial release                                             |
// +-----------------------------------------------------------------------------+

module brent_kung_adder_nbit #(
   parameter int ADDER_SIZE = 32
) (
   input  logic [ADDER_SIZE-1:0] i_a,
   input  logic [ADDER_SIZE-1:0] i_b,
   input  logic                  i_cin,
   output logic [ADDER_SIZE-1:0] o_sum,
   output logic                  o_cout
);

   localparam int c_levels = $clog2(ADDER_SIZE);
   localparam logic [ADDER_SIZE-1:0] c_one = {{(ADDER_SIZE-1){1'b0}}, 1'b1};

   // Selects the prefix-tree nodes combined at one level: bits start+off, start+off+span, ...
   function automatic logic [ADDER_SIZE-1:0] node_mask(input int span, input int start, input int off);
      logic [ADDER_SIZE-1:0] m;
      m = '0;
      for (int k = start; k + off < ADDER_SIZE; k += span)
         m = m | (c_one << (k + off));
      return m;
   endfunction

   logic [ADDER_SIZE-1:0] w_p;
   logic [ADDER_SIZE-1:0] w_gg;
   logic [ADDER_SIZE-1:0] w_gp;
   logic [ADDER_SIZE-1:0] w_m;

   // Carry-in is folded into bit 0 generate so the tree yields true carries directly.
   always_comb begin
      w_p  = i_a ^ i_b;
      w_gg = (i_a & i_b) | (w_p & (i_cin ? c_one : '0));
      w_gp = w_p;
      w_m  = '0;
      for (int l = 1; l <= c_levels; l++) begin
         w_m  = node_mask(1 << l, 0, (1 << l) - 1);
         w_gg = w_gg | (w_gp & (w_gg << (1 << (l - 1))) & w_m);
         w_gp = w_gp & ((w_gp << (1 << (l - 1))) | ~w_m);
      end
      for (int d = c_levels - 1; d >= 1; d--) begin
         w_m  = node_mask(1 << d, 1 << d, (1 << (d - 1)) - 1);
         w_gg = w_gg | (w_gp & (w_gg << (1 << (d - 1))) & w_m);
         w_gp = w_gp & ((w_gp << (1 << (d - 1))) | ~w_m);
      end
   end

   assign o_sum  = w_p ^ {w_gg[ADDER_SIZE-2:0], i_cin};
   assign o_cout = w_gg[ADDER_SIZE-1];

endmodule

module bk_adder_arbiter #(
   parameter int ADDER_SIZE = 32,
   parameter int NUM_REQ    = 4,
   parameter int ID_W       = $clog2(NUM_REQ)
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_REQ-1:0]            req_valid,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic [NUM_REQ*ADDER_SIZE-1:0] req_op1,
   input  logic [NUM_REQ*ADDER_SIZE-1:0] req_op2,
   input  logic [NUM_REQ-1:0]            req_cin,
   output logic                          rsp_valid,
   input  logic                          rsp_ready,
   output logic [ADDER_SIZE-1:0]         rsp_res,
   output logic                          rsp_cout,
   output logic [ID_W-1:0]               rsp_id,
   output logic                          busy
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t                r_state;
   logic [ID_W-1:0]       r_rr_ptr;
   logic [ID_W-1:0]       r_id;
   logic [ADDER_SIZE-1:0] r_op1;
   logic [ADDER_SIZE-1:0] r_op2;
   logic                  r_cin;

   logic                  w_gnt_any;
   logic [ID_W-1:0]       w_gnt_id;
   logic [ID_W-1:0]       w_next_ptr;
   int                    w_idx;
   int                    w_nxt;
   logic [ADDER_SIZE-1:0] w_sel_op1;
   logic [ADDER_SIZE-1:0] w_sel_op2;
   logic                  w_sel_cin;
   logic [ADDER_SIZE-1:0] w_sum;
   logic                  w_cout;

   // Scan from highest offset down so the lowest offset from rr_ptr wins.
   always_comb begin
      w_gnt_any = 1'b0;
      w_gnt_id  = '0;
      w_idx     = 0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         w_idx = int'(r_rr_ptr) + k;
         if (w_idx >= NUM_REQ)
            w_idx = w_idx - NUM_REQ;
         if (req_valid[w_idx]) begin
            w_gnt_any = 1'b1;
            w_gnt_id  = ID_W'(w_idx);
         end
      end
   end

   always_comb begin
      w_nxt = int'(w_gnt_id) + 1;
      if (w_nxt >= NUM_REQ)
         w_nxt = 0;
      w_next_ptr = ID_W'(w_nxt);
   end

   always_comb begin
      w_sel_op1 = '0;
      w_sel_op2 = '0;
      w_sel_cin = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_gnt_id == ID_W'(i)) begin
            w_sel_op1 = req_op1[i*ADDER_SIZE +: ADDER_SIZE];
            w_sel_op2 = req_op2[i*ADDER_SIZE +: ADDER_SIZE];
            w_sel_cin = req_cin[i];
         end
      end
   end

   assign req_ready = (rst_n && (r_state == S_IDLE) && w_gnt_any)
                      ? (NUM_REQ'(1) << w_gnt_id) : '0;

   brent_kung_adder_nbit #(
      .ADDER_SIZE (ADDER_SIZE)
   ) u_adder (
      .i_a    (r_op1),
      .i_b    (r_op2),
      .i_cin  (r_cin),
      .o_sum  (w_sum),
      .o_cout (w_cout)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_rr_ptr  <= '0;
         r_id      <= '0;
         r_op1     <= '0;
         r_op2     <= '0;
         r_cin     <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_res   <= '0;
         rsp_cout  <= 1'b0;
         rsp_id    <= '0;
         busy      <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_gnt_any) begin
                  r_op1    <= w_sel_op1;
                  r_op2    <= w_sel_op2;
                  r_cin    <= w_sel_cin;
                  r_id     <= w_gnt_id;
                  r_rr_ptr <= w_next_ptr;
                  r_state  <= S_EXEC;
                  busy     <= 1'b1;
               end
            end
            S_EXEC: begin
               rsp_res   <= w_sum;
               rsp_cout  <= w_cout;
               rsp_id    <= r_id;
               rsp_valid <= 1'b1;
               r_state   <= S_RESP;
            end
            S_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  busy      <= 1'b0;
                  r_state   <= S_IDLE;
               end
            end
            default: begin
               rsp_valid <= 1'b0;
               busy      <= 1'b0;
               r_state   <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
